// File: rtl/cpu_pkg.sv
// Shared MIPS front-end types and constants: opcodes, BHT counter type, default vectors.
package cpu_pkg;

   localparam logic [5:0]  OP_BEQ = 6'h04;
   localparam logic [5:0]  OP_BNE = 6'h05;

   typedef logic [1:0] bht_ctr_t;
   localparam bht_ctr_t    CTR_WEAK_NT = 2'b01;

   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;

endpackage

// File: rtl/branch_history_table.sv
// Table of 2-bit saturating branch counters: combinational read, clocked write.
module branch_history_table
   import cpu_pkg::*;
#(
   parameter int ENTRIES = 16,
   localparam int IW = $clog2(ENTRIES)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [IW-1:0] rd_idx_i,
   output bht_ctr_t      rd_ctr_o,
   input  logic          wr_en_i,
   input  logic [IW-1:0] wr_idx_i,
   input  logic          wr_taken_i
);

   bht_ctr_t ctr_q [ENTRIES];
   bht_ctr_t wr_cur, wr_nxt;

   // Read returns the stored value, so a same-index write this cycle is not visible yet.
   assign rd_ctr_o = ctr_q[rd_idx_i];
   assign wr_cur   = ctr_q[wr_idx_i];

   always_comb begin
      wr_nxt = wr_cur;
      if (wr_taken_i && wr_cur != 2'b11)
         wr_nxt = wr_cur + 2'b01;
      else if (!wr_taken_i && wr_cur != 2'b00)
         wr_nxt = wr_cur - 2'b01;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_WEAK_NT;
      end else if (wr_en_i) begin
         ctr_q[wr_idx_i] <= wr_nxt;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, next-PC selection and IF/ID register.
// Define BHT_PREDICT_EN to add the branch history table predicting beq/bne in IF.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
   parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(DEF_EXC_VECTOR),
   parameter int              BHT_ENTRIES  = 16
) (
   input  logic            clk,
   input  logic            reset,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   input  logic            stall,
   input  logic            flush,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            exc_valid,
   input  logic            bht_upd_valid,
   input  logic [XLEN-1:0] bht_upd_pc,
   input  logic            bht_upd_taken,
   output logic            ifid_valid,
   output logic [31:0]     ifid_instr,
   output logic [XLEN-1:0] ifid_pc,
   output logic [XLEN-1:0] ifid_pc_plus_4,
   output logic            ifid_pred_taken
);

   logic [XLEN-1:0]  pc_q, pc_d, pc_plus_4, br_off;
   logic [XLEN+17:0] br_off_wide;
   logic             pred_taken, kill;

   assign imem_addr   = pc_q;
   assign pc_plus_4   = pc_q + XLEN'(4);
   // Sign-extend {imm16,2'b00} past XLEN first, then truncate, so small XLEN still works.
   assign br_off_wide = {{XLEN{imem_rdata[15]}}, imem_rdata[15:0], 2'b00};
   assign br_off      = br_off_wide[XLEN-1:0];

`ifdef BHT_PREDICT_EN
   localparam int IDXW = $clog2(BHT_ENTRIES);
   bht_ctr_t rd_ctr;
   logic     is_branch;
   logic     unused_upd_pc;

   assign is_branch     = (imem_rdata[31:26] == OP_BEQ) || (imem_rdata[31:26] == OP_BNE);
   assign pred_taken    = is_branch && rd_ctr[1];
   assign unused_upd_pc = ^bht_upd_pc;

   branch_history_table #(.ENTRIES(BHT_ENTRIES)) u_bht (
      .clk        (clk),
      .reset      (reset),
      .rd_idx_i   (pc_q[IDXW+1:2]),
      .rd_ctr_o   (rd_ctr),
      .wr_en_i    (bht_upd_valid),
      .wr_idx_i   (bht_upd_pc[IDXW+1:2]),
      .wr_taken_i (bht_upd_taken)
   );
`else
   logic unused_bht;
   assign pred_taken = 1'b0;
   assign unused_bht = ^{bht_upd_valid, bht_upd_pc, bht_upd_taken};
`endif

   always_comb begin
      pc_d = pc_plus_4;
      if (exc_valid)           pc_d = EXC_VECTOR;
      else if (redirect_valid) pc_d = {redirect_target[XLEN-1:2], 2'b00};
      else if (stall)          pc_d = pc_q;
      else if (pred_taken)     pc_d = pc_plus_4 + br_off;
   end

   assign kill = exc_valid || redirect_valid || flush;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q            <= RESET_VECTOR;
         ifid_valid      <= 1'b0;
         ifid_instr      <= '0;
         ifid_pc         <= '0;
         ifid_pc_plus_4  <= '0;
         ifid_pred_taken <= 1'b0;
      end else begin
         pc_q <= pc_d;
         if (kill) begin
            ifid_valid <= 1'b0;
         end else if (!stall) begin
            ifid_valid      <= 1'b1;
            ifid_instr      <= imem_rdata;
            ifid_pc         <= pc_q;
            ifid_pc_plus_4  <= pc_plus_4;
            ifid_pred_taken <= pred_taken;
         end
      end
   end

endmodule
